// File: rtl/dcram_banked.sv
// N-bank data-cache RAM: byte-enabled writes, write-first reads with lane rotation,
// a self-clearing init sequencer and per-byte even parity with error reporting.
module dcram_banked #(
  parameter int NBANK  = 2,
  parameter int WORD_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           enable_i,
  input  logic [IDX_W+$clog2(NBANK)+1:0] addr_i,
  input  logic [WORD_W/8-1:0]            we_i,
  input  logic [NBANK-1:0]               bank_sel_i,
  input  logic [NBANK*WORD_W-1:0]        data_in_i,
  input  logic                           bypass_i,
  input  logic                           par_inj_i,
  input  logic                           init_req_i,
  output logic [NBANK*WORD_W-1:0]        data_out_o,
  output logic                           rd_valid_o,
  output logic                           busy_o,
  output logic [NBANK-1:0]               par_err_o
);

  localparam int BE_W  = WORD_W / 8;
  localparam int DEPTH = 2 ** IDX_W;
  localparam int RB    = $clog2(NBANK);
  localparam int AW    = IDX_W + RB + 2;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic             accept;
  logic [IDX_W-1:0] req_line;
  logic             unused_addr;

  assign busy_o      = (state_q == ST_INIT);
  assign accept      = enable_i & ~busy_o;
  assign req_line    = addr_i[AW-1:RB+2];
  assign unused_addr = ^addr_i[1:0];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_INIT: begin
        count_d = count_q + IDX_W'(1);
        if (count_q == {IDX_W{1'b1}}) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (init_req_i) begin
          state_d = ST_INIT;
          count_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_INIT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Request capture stage
  logic                    s1_vld_q;
  logic [IDX_W-1:0]        s1_line_q;
  logic [RB-1:0]           s1_rot_q;
  logic [BE_W-1:0]         s1_we_q;
  logic [NBANK-1:0]        s1_sel_q;
  logic [NBANK*WORD_W-1:0] s1_data_q;
  logic                    s1_byp_q;
  logic                    s1_inj_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) s1_vld_q <= 1'b0;
    else         s1_vld_q <= accept;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_line_q <= req_line;
      s1_rot_q  <= addr_i[RB+1:2];
      s1_we_q   <= we_i;
      s1_sel_q  <= bank_sel_i;
      s1_data_q <= data_in_i;
      s1_byp_q  <= bypass_i;
      s1_inj_q  <= par_inj_i;
    end
  end

  // Single write port per bank; the init sequencer owns it while busy, so a
  // request accepted together with init_req never reaches the array.
  logic [IDX_W-1:0]  wr_line;
  logic [BE_W-1:0]   wr_be   [NBANK];
  logic [WORD_W-1:0] wr_data [NBANK];
  logic [BE_W-1:0]   wr_par  [NBANK];
  logic              wr_any;

  always_comb begin
    wr_line = busy_o ? count_q : s1_line_q;
    wr_any  = 1'b0;
    for (int b = 0; b < NBANK; b++) begin
      wr_be[b]   = '0;
      wr_data[b] = '0;
      wr_par[b]  = '0;
      if (busy_o) begin
        wr_be[b] = '1;
      end else if (s1_vld_q && s1_sel_q[b]) begin
        wr_be[b]   = s1_we_q;
        wr_data[b] = s1_data_q[b*WORD_W +: WORD_W];
        for (int i = 0; i < BE_W; i++)
          wr_par[b][i] = (^s1_data_q[b*WORD_W + i*8 +: 8]) ^ s1_inj_q;
      end
      wr_any = wr_any | (|wr_be[b]);
    end
  end

  // Last write, replayed over a read issued at the same edge (read-old array).
  logic              fw_vld_q;
  logic [IDX_W-1:0]  fw_line_q;
  logic [BE_W-1:0]   fw_be_q   [NBANK];
  logic [WORD_W-1:0] fw_data_q [NBANK];
  logic [BE_W-1:0]   fw_par_q  [NBANK];

  always_ff @(posedge clk_i) begin
    if (reset_i) fw_vld_q <= 1'b0;
    else         fw_vld_q <= wr_any;
  end

  always_ff @(posedge clk_i) begin
    fw_line_q <= wr_line;
    for (int b = 0; b < NBANK; b++) begin
      fw_be_q[b]   <= wr_be[b];
      fw_data_q[b] <= wr_data[b];
      fw_par_q[b]  <= wr_par[b];
    end
  end

  logic [WORD_W-1:0] rd_word [NBANK];
  logic [BE_W-1:0]   rd_par  [NBANK];

  for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
    logic [WORD_W-1:0] mem_q     [DEPTH];
    logic [BE_W-1:0]   par_mem_q [DEPTH];
    logic [WORD_W-1:0] rd_q;
    logic [BE_W-1:0]   rdp_q;

    always_ff @(posedge clk_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[gi][i]) begin
          mem_q[wr_line][i*8 +: 8] <= wr_data[gi][i*8 +: 8];
          par_mem_q[wr_line][i]    <= wr_par[gi][i];
        end
      end
      if (accept) begin
        rd_q  <= mem_q[req_line];
        rdp_q <= par_mem_q[req_line];
      end
    end

    assign rd_word[gi] = rd_q;
    assign rd_par[gi]  = rdp_q;
  end

  logic              fw_hit;
  logic              wbit;
  logic              pbit;
  logic [WORD_W-1:0] merged [NBANK];
  logic [NBANK-1:0]  perr;

  always_comb begin
    fw_hit = fw_vld_q && (fw_line_q == s1_line_q);
    wbit   = 1'b0;
    pbit   = 1'b0;
    perr   = '0;
    for (int b = 0; b < NBANK; b++) begin
      merged[b] = rd_word[b];
      for (int i = 0; i < BE_W; i++) begin
        wbit = s1_sel_q[b] & s1_we_q[i];
        if (wbit) begin
          merged[b][i*8 +: 8] = s1_data_q[b*WORD_W + i*8 +: 8];
          pbit = (^s1_data_q[b*WORD_W + i*8 +: 8]) ^ s1_inj_q;
        end else if (fw_hit && fw_be_q[b][i]) begin
          merged[b][i*8 +: 8] = fw_data_q[b][i*8 +: 8];
          pbit = fw_par_q[b][i];
        end else begin
          pbit = rd_par[b][i];
        end
        if (!wbit && (pbit != ^merged[b][i*8 +: 8])) perr[b] = 1'b1;
      end
    end
  end

  logic [NBANK*WORD_W-1:0] data_out_d;
  logic [RB-1:0]           src;

  always_comb begin
    data_out_d = '0;
    src        = '0;
    for (int k = 0; k < NBANK; k++) begin
      src = RB'(k) + s1_rot_q;
      data_out_d[k*WORD_W +: WORD_W] = s1_byp_q ? s1_data_q[WORD_W-1:0] : merged[src];
    end
  end

  logic [NBANK*WORD_W-1:0] data_out_q;
  logic                    rd_valid_q;
  logic [NBANK-1:0]        par_err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      par_err_q  <= '0;
    end else begin
      rd_valid_q <= s1_vld_q;
      par_err_q  <= (s1_vld_q && !s1_byp_q) ? perr : '0;
      if (s1_vld_q) data_out_q <= data_out_d;
    end
  end

  assign data_out_o = data_out_q;
  assign rd_valid_o = rd_valid_q;
  assign par_err_o  = par_err_q;

endmodule

// File: tb/tb_dcram_banked.sv
// Bench for dcram_banked: directed scenarios plus random traffic, every cycle
// compared against a byte-array reference model with sequential request semantics.
module tb_dcram_banked;

  localparam int NBANK  = 2;
  localparam int WORD_W = 32;
  localparam int IDX_W  = 8;
  localparam int BE_W   = WORD_W / 8;
  localparam int DEPTH  = 2 ** IDX_W;
  localparam int RB     = $clog2(NBANK);
  localparam int AW     = IDX_W + RB + 2;
  localparam int DW     = NBANK * WORD_W;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [AW-1:0]     addr;
  logic [BE_W-1:0]   we;
  logic [NBANK-1:0]  bank_sel;
  logic [DW-1:0]     data_in;
  logic              bypass;
  logic              par_inj;
  logic              init_req;
  logic [DW-1:0]     data_out;
  logic              rd_valid;
  logic              busy;
  logic [NBANK-1:0]  par_err;

  dcram_banked #(.NBANK(NBANK), .WORD_W(WORD_W), .IDX_W(IDX_W)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .enable_i   (enable),
    .addr_i     (addr),
    .we_i       (we),
    .bank_sel_i (bank_sel),
    .data_in_i  (data_in),
    .bypass_i   (bypass),
    .par_inj_i  (par_inj),
    .init_req_i (init_req),
    .data_out_o (data_out),
    .rd_valid_o (rd_valid),
    .busy_o     (busy),
    .par_err_o  (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain byte arrays plus a "parity corrupted" flag per byte.
  logic [7:0]       m_byte [NBANK][DEPTH][BE_W];
  bit               m_bad  [NBANK][DEPTH][BE_W];
  int               busy_left;
  bit               pend_v;
  logic [DW-1:0]    pend_data;
  logic [NBANK-1:0] pend_perr;
  logic [DW-1:0]    last_out;
  int               checks;
  int               errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < NBANK; b++)
      for (int l = 0; l < DEPTH; l++)
        for (int i = 0; i < BE_W; i++) begin
          m_byte[b][l][i] = 8'h00;
          m_bad[b][l][i]  = 1'b0;
        end
  endtask

  task automatic step(input bit rst, input bit en, input logic [AW-1:0] a,
                      input logic [BE_W-1:0] w, input logic [NBANK-1:0] s,
                      input logic [DW-1:0] d, input bit byp, input bit inj, input bit ini);
    int               line;
    int               rot;
    bit               cur_v;
    logic [NBANK-1:0] cur_p;
    bit               nv;
    logic [DW-1:0]    nd;
    logic [NBANK-1:0] np;
    logic [WORD_W-1:0] word [NBANK];
    reset    = rst;
    enable   = en;
    addr     = a;
    we       = w;
    bank_sel = s;
    data_in  = d;
    bypass   = byp;
    par_inj  = inj;
    init_req = ini;
    @(posedge clk);
    nv    = 1'b0;
    nd    = '0;
    np    = '0;
    cur_v = 1'b0;
    cur_p = '0;
    if (rst) begin
      model_clear();
      busy_left = DEPTH;
      last_out  = '0;
    end else begin
      cur_v = pend_v;
      cur_p = pend_perr;
      if (pend_v) last_out = pend_data;
      if (en && busy_left == 0) begin
        nv   = 1'b1;
        line = int'(a[AW-1:RB+2]);
        rot  = int'(a[RB+1:2]);
        for (int b = 0; b < NBANK; b++)
          for (int i = 0; i < BE_W; i++)
            if (s[b] && w[i]) begin
              m_byte[b][line][i] = d[b*WORD_W + i*8 +: 8];
              m_bad[b][line][i]  = inj;
            end
        for (int b = 0; b < NBANK; b++) begin
          for (int i = 0; i < BE_W; i++) begin
            word[b][i*8 +: 8] = m_byte[b][line][i];
            if (m_bad[b][line][i] && !(s[b] && w[i])) np[b] = 1'b1;
          end
        end
        for (int k = 0; k < NBANK; k++)
          nd[k*WORD_W +: WORD_W] = byp ? d[WORD_W-1:0] : word[(k + rot) % NBANK];
        if (byp) np = '0;
      end
      if (busy_left > 0) busy_left--;
      else if (ini) begin
        busy_left = DEPTH;
        model_clear();
      end
    end
    pend_v    = nv;
    pend_data = nd;
    pend_perr = np;
    #1;
    check("rd_valid", 64'(rd_valid), 64'(cur_v));
    check("data_out", 64'(data_out), 64'(last_out));
    check("par_err", 64'(par_err), 64'(cur_p));
    check("busy", 64'(busy), 64'(busy_left > 0));
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(0, 0, '0, '0, '0, '0, 0, 0, 0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(0, 1, a, '0, '0, '0, 0, 0, 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    busy_left = DEPTH;
    pend_v    = 1'b0;
    pend_data = '0;
    pend_perr = '0;
    last_out  = '0;
    model_clear();

    // Reset, then wait out the init sweep
    step(1, 0, '0, '0, '0, '0, 0, 0, 0);
    step(1, 0, '0, '0, '0, '0, 0, 0, 0);
    idle(DEPTH + 2);
    check("busy_after_init", 64'(busy), 64'(0));
    rd('0);
    rd(AW'((DEPTH - 1) << (RB + 2)));
    idle(2);

    // Full-line write, identity and rotated reads
    step(0, 1, AW'('h10), 4'hF, 2'b11, 64'h11112222_33334444, 0, 0, 0);
    rd(AW'('h10));
    rd(AW'('h14));
    check("t2_ident", data_out, 64'h11112222_33334444);
    idle(1);
    check("t2_rot", data_out, 64'h33334444_11112222);
    idle(1);

    // Single-byte write then back-to-back read
    step(0, 1, AW'('h10), 4'b0010, 2'b01, 64'h00000000_0000AB00, 0, 0, 0);
    rd(AW'('h10));
    idle(2);
    check("t3_b2b", data_out, 64'h11112222_3333AB44);

    // Bypass with no bank selected
    step(0, 1, AW'('h10), 4'hF, 2'b00, 64'h00000000_DEADBEEF, 1, 0, 0);
    idle(1);
    check("t4_bypass", data_out, 64'hDEADBEEF_DEADBEEF);
    check("t4_perr", 64'(par_err), 64'(0));
    rd(AW'('h10));
    idle(1);
    check("t4_unchanged", data_out, 64'h11112222_3333AB44);
    idle(1);

    // Parity injection on bank 1 MSbyte, then repair
    step(0, 1, AW'('h20), 4'b1000, 2'b10, 64'h5A000000_00000000, 0, 1, 0);
    rd(AW'('h20));
    idle(1);
    check("t5_inj_perr", 64'(par_err), 64'(2'b10));
    idle(1);
    step(0, 1, AW'('h20), 4'b1000, 2'b10, 64'h5A000000_00000000, 0, 0, 0);
    rd(AW'('h20));
    idle(1);
    check("t5_fixed_perr", 64'(par_err), 64'(0));
    idle(1);

    // Init request with enable held high, reset mid-sweep
    step(0, 1, AW'('h20), '0, '0, '0, 0, 0, 1);
    for (int j = 0; j < 100; j++) rd(AW'('h10));
    step(1, 1, AW'('h10), '0, '0, '0, 0, 0, 0);
    for (int j = 0; j < DEPTH + 4; j++) rd(AW'('h10));

    // Random traffic concentrated on a few lines to exercise forwarding
    for (int n = 0; n < 3000; n++) begin
      int r;
      int line;
      logic [AW-1:0] a;
      r    = int'($urandom_range(0, 999));
      line = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                         : int'($urandom_range(0, 3));
      a    = AW'((line << (RB + 2)) | int'($urandom_range(0, (4 << RB) - 1)));
      step(r == 0, $urandom_range(0, 7) != 0, a, BE_W'($urandom), NBANK'($urandom),
           {$urandom, $urandom}, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           r >= 1 && r <= 2);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
